// File: rtl/cic3_interp_sdm_dac_if.sv
// Sample/bitstream bundle for cic3_interp_sdm_dac: driver side is master, DAC is slave.
interface cic3_interp_sdm_dac_if #(
   parameter int IN_WIDTH = 16
);
   logic signed [IN_WIDTH-1:0] in_data;
   logic                       in_valid;
   logic                       in_ready;
   logic                       underrun;
   logic                       dout;

   modport master (
      output in_data,
      output in_valid,
      input  in_ready,
      input  underrun,
      input  dout
   );

   modport slave (
      input  in_data,
      input  in_valid,
      output in_ready,
      output underrun,
      output dout
   );
endinterface

// File: rtl/cic3_interp_sdm_dac.sv
// CIC3 x R interpolator feeding a 1st-order sigma-delta: one sample per R clks in, 1 bit per clk out.
// Latency: sample hits u one clk after its slot; y settles within 3R+4 clks; dout registered.
// Backpressure: none beyond the one-cycle in_ready slot; missed slot holds x and pulses underrun. Dither: CIC3_INTERP_SDM_DITHER_EN.
module cic3_interp_sdm_dac #(
   parameter int DECIMATION_FACTOR = 256,
   parameter int CLOCK_WIDTH       = $clog2(DECIMATION_FACTOR),
   parameter int IN_WIDTH          = 16,
   parameter int W                 = IN_WIDTH + 3*CLOCK_WIDTH
) (
   input  logic                  clk,
   input  logic                  reset,
   cic3_interp_sdm_dac_if.slave  bus
);
   localparam int AW = IN_WIDTH + 2;
   localparam logic signed [AW-1:0] FULL = AW'(2**(IN_WIDTH-1));

   logic [CLOCK_WIDTH-1:0]     ph;
   logic                       slot;
   logic signed [IN_WIDTH-1:0] x;
   logic signed [IN_WIDTH-1:0] x_new;
   logic signed [W-1:0]        x_w, x_new_w;
   logic signed [W-1:0]        d1, d2, d3, d1_z, d2_z, comb_out;
   logic signed [W-1:0]        u, i1, i2, i3;
   logic signed [AW-1:0]       y, v, fb, acc, dither;
   logic                       dout_next;
   logic                       dout_q;
   logic                       underrun_q;

   assign slot         = (ph == CLOCK_WIDTH'(DECIMATION_FACTOR-1));
   assign bus.in_ready = slot && !reset;
   assign bus.dout     = dout_q;
   assign bus.underrun = underrun_q;

`ifdef CIC3_INTERP_SDM_DITHER_EN
   logic [15:0] lfsr;

   always_ff @(posedge clk) begin
      if (reset) lfsr <= 16'hACE1;
      else       lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
   end

   assign dither = {{(AW-1){1'b0}}, lfsr[0]};
`else
   assign dither = '0;
`endif

   always_comb begin
      x_new   = bus.in_valid ? bus.in_data : x;
      x_w     = x;
      x_new_w = x_new;
      // x itself is the comb's x_z: it only moves at accept edges
      d1 = x_new_w - x_w;
      d2 = d1 - d1_z;
      d3 = d2 - d2_z;
      u  = (ph == '0) ? comb_out : '0;
      // low AW bits of i3 >>> 2*CLOCK_WIDTH; exact because R^2 gain cancels
      y  = i3[2*CLOCK_WIDTH +: AW];
      v  = acc + y + dither;
      dout_next = !v[AW-1];
      fb = dout_next ? FULL : -FULL;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         ph         <= '0;
         x          <= '0;
         d1_z       <= '0;
         d2_z       <= '0;
         comb_out   <= '0;
         i1         <= '0;
         i2         <= '0;
         i3         <= '0;
         acc        <= '0;
         dout_q     <= 1'b0;
         underrun_q <= 1'b0;
      end else begin
         ph         <= ph + CLOCK_WIDTH'(1);
         underrun_q <= slot && !bus.in_valid;
         if (slot) begin
            x        <= x_new;
            d1_z     <= d1;
            d2_z     <= d2;
            comb_out <= d3;
         end
         // integrators wrap mod 2^W; the comb differences cancel the wrap
         i1     <= i1 + u;
         i2     <= i2 + i1;
         i3     <= i3 + i2;
         acc    <= v - fb;
         dout_q <= dout_next;
      end
   end
endmodule

// File: doc/cic3_interp_sdm_dac.md
# cic3_interp_sdm_dac

Digital-to-bitstream path: accepts signed multi-bit samples at the decimated rate, interpolates by DECIMATION_FACTOR with a 3rd-order CIC interpolator, and drives a first-order digital sigma-delta modulator producing a 1-bit stream at the clk rate. It is the transmit counterpart of the sdm → cic3_accumulators → cic3_differentiators decimation chain. A bench can therefore feed its dout straight back into that chain as a loopback.

## Interface
- DECIMATION_FACTOR, 256, interpolation ratio R; power of two, ≥ 4
- CLOCK_WIDTH, $clog2(DECIMATION_FACTOR), phase counter width
- IN_WIDTH, 16, signed input sample width
- W, IN_WIDTH+3*CLOCK_WIDTH, CIC internal register width
- clk  input  1  single clock, all logic on rising edge
- reset  input  1  synchronous, active-high reset
- in_data  input  IN_WIDTH  signed two's-complement sample
- in_valid  input  1  in_data valid
- in_ready  output  1  sample slot; transfer when in_valid && in_ready
- underrun  output  1  one-cycle pulse: slot passed with in_valid low
- dout  output  1  modulator bitstream; 1 = +full scale, 0 = −full scale

## Operation
- Phase counter ph: 0..R-1, +1 per clk, wraps R-1→0.
- in_ready = (ph == R-1) && !reset. Combinational.
- Accept edge is the edge ending ph==R-1:
  - Transfer: x ← in_data.
  - in_valid low: x ← previous x (hold last sample); underrun = 1 the next cycle.
- Comb section, evaluated once per accept edge on x:
  - d1 = x − x_z; d2 = d1 − d1_z; d3 = d2 − d2_z.
  - Delays update only at accept edges. Sign-extend to W.
  - Result registered into comb_out.
- Zero-stuff: u = comb_out when ph == 0, else 0.
- Integrators, every clk, registered cascade using pre-edge values:
  - i1 += u; i2 += i1; i3 += i2.
  - Modulo 2^W wrap, no saturation.
- Scaling: y = i3 >>> (2*CLOCK_WIDTH), arithmetic shift. CIC gain R² is exact, so y ∈ IN_WIDTH range.
- Modulator, accumulator acc signed IN_WIDTH+2:
  - v = acc + y (+ dither).
  - dout_next = (v ≥ 0).
  - acc ← v − (dout_next ? 2^(IN_WIDTH-1) : −2^(IN_WIDTH-1)).
- Ones density in steady state = (y + 2^(IN_WIDTH-1)) / 2^IN_WIDTH.

## Timing
- Reset values: ph=0, x and all comb delays 0, comb_out=0, i1..i3=0, acc=0, dout=0, underrun=0, in_ready=0.
- First in_ready: cycle R-1 after reset deasserts.
- in_ready is high exactly 1 of every R cycles. No backpressure beyond the slot; in_valid outside the slot is ignored.
- dout is registered and changes every clk.
- Constant input step: y reaches its final value within 3R+4 cycles of the accept edge.
- Reset mid-operation:
  - Every register clears on that edge.
  - A sample presented during reset is never accepted.
  - Phase restarts at 0.
- Simultaneous underrun and reset: reset wins, so underrun stays 0.
- Integrator wrap is intentional. Comb differences cancel it, so y is exact for in-range inputs.

## Configuration
- CIC3_INTERP_SDM_DITHER_EN defined:
  - 16-bit Fibonacci LFSR, taps x^16+x^14+x^13+x^11+1, seed 16'hACE1 on reset, steps every clk.
  - LFSR bit 0 (0 or +1 LSB) is added into v.
- Not defined: no LFSR logic; dither is constant 0 and dout is fully deterministic.

## Test plan
- Reset: hold reset 5 cycles with in_valid=1 → dout=0, in_ready=0, underrun=0 throughout; first in_ready pulse at cycle R-1 after release.
- Zero input (dither off): in_data=0 every slot → after settling, dout alternates 1,0,1,0; exactly R/2 ones per R-cycle window.
- DC level: in_data=16'sh4000 steadily → after 3R+4 cycles, ones per R-cycle window = 3R/4 ±1; loopback through the decimator reads a steady value.
- Handshake/underrun: drop in_valid for one slot → single-cycle underrun pulse the cycle after that slot; the held sample keeps the DC density unchanged.
- Mid-stream reset: assert reset for one cycle at ph=R/2 during a full-scale input 16'sh7FFF → next cycle all state is zero; stream restarts identically to a cold reset.
- Dither build: define CIC3_INTERP_SDM_DITHER_EN, in_data=0 → dout is no longer a strict 1,0 alternation; long-window density stays 0.5 ±1/R.
